axilite_slave_regfile: RTL and testbench

- AXI4-Lite responder (slave) RTL: the other end of the AXI-Lite master interface driven by the tx agent's driver.
- Holds NUM_REGS memory-mapped registers of DATA_WIDTH bits. Accepts writes with byte strobes and serves reads.
- Returns OKAY or SLVERR responses.
- Serves as the DUT/target model for the axilite testbench, and as a reusable control/status register block.

---
 rtl/axilite_slave_regfile.sv | 182 ++++++++++++++++++
 tb/tb_axilite_slave_regfile.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_slave_regfile.sv
// AXI4-Lite register file responder: NUM_REGS word registers with byte strobes,
// independent write/read channel FSMs, SLVERR on out-of-range word indices.
module axilite_slave_regfile #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic [2:0]                     awprot,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic [2:0]                     arprot,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
   localparam int unsigned SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  aw_latch, w_latch, commit;
   logic [IDX_W-1:0]      c_idx;
   logic [DATA_WIDTH-1:0] c_data;
   logic [STRB_W-1:0]     c_strb;
   logic [IDX_W-1:0]      ar_idx;
   logic                  unused_bits;

   assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign ar_hs  = arvalid && arready;
   assign ar_idx = araddr[ADDR_WIDTH-1:2];

   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return 32'(idx) < NUM_REGS;
   endfunction

   // Write channel next-state; the commit source mixes live and latched halves
   always_comb begin
      w_next   = w_state;
      aw_latch = 1'b0;
      w_latch  = 1'b0;
      commit   = 1'b0;
      c_idx    = awaddr[ADDR_WIDTH-1:2];
      c_data   = wdata;
      c_strb   = wstrb;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               w_next = W_RESP;
            end else if (aw_hs) begin
               aw_latch = 1'b1;
               w_next   = W_WAIT_DATA;
            end else if (w_hs) begin
               w_latch = 1'b1;
               w_next  = W_WAIT_ADDR;
            end
         end
         W_WAIT_DATA: begin
            c_idx = aw_idx_q;
            if (w_hs) begin
               commit = 1'b1;
               w_next = W_RESP;
            end
         end
         W_WAIT_ADDR: begin
            c_data = wdata_q;
            c_strb = wstrb_q;
            if (aw_hs) begin
               commit = 1'b1;
               w_next = W_RESP;
            end
         end
         W_RESP:  if (bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Ready flags are registered from the next state so they stay low during reset
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state  <= W_IDLE;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bresp    <= OKAY;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         w_state <= w_next;
         awready <= (w_next == W_IDLE) || (w_next == W_WAIT_ADDR);
         wready  <= (w_next == W_IDLE) || (w_next == W_WAIT_DATA);
         bvalid  <= (w_next == W_RESP);
         if (commit)   bresp    <= in_range(c_idx) ? OKAY : SLVERR;
         if (aw_latch) aw_idx_q <= awaddr[ADDR_WIDTH-1:2];
         if (w_latch) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= RESET_VALUE;
      end else if (commit && in_range(c_idx)) begin
         for (int b = 0; b < int'(STRB_W); b++)
            if (c_strb[b]) regs[c_idx[SEL_W-1:0]][8*b +: 8] <= c_data[8*b +: 8];
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_RESP;
         R_RESP:  if (rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Read data samples the flops before any same-edge write lands
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= OKAY;
      end else begin
         r_state <= r_next;
         arready <= (r_next == R_IDLE);
         rvalid  <= (r_next == R_RESP);
         if (ar_hs) begin
            if (in_range(ar_idx)) begin
               rdata <= regs[ar_idx[SEL_W-1:0]];
               rresp <= OKAY;
            end else begin
               rdata <= '0;
               rresp <= SLVERR;
            end
         end
      end
   end

   for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_flat
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
   end

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Directed bench for axilite_slave_regfile; B/R responses are checked by a
// queue-based monitor, timing/level properties are checked inline.
module tb_axilite_slave_regfile;

   localparam int unsigned NR = 16;
   localparam int unsigned RW = NR * 32;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   logic          aclk, areset;
   logic [7:0]    awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [RW-1:0] regs_o;

   int vectors = 0;
   int errors  = 0;
   logic [1:0]  exp_b[$];
   rexp_t       exp_r[$];
   logic [31:0] mdl [NR];

   axilite_slave_regfile dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .regs_o(regs_o)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] flat();
      logic [RW-1:0] f;
      for (int i = 0; i < int'(NR); i++) f[i*32 +: 32] = mdl[i];
      return f;
   endfunction

   // Scoreboard monitor: pops an expectation on every accepted response
   always @(negedge aclk) begin
      if (!areset) begin
         if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", RW'(bresp), RW'(exp_b.pop_front()));
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
            else begin
               rexp_t e;
               e = exp_r.pop_front();
               chk("rdata", RW'(rdata), RW'(e.d));
               chk("rresp", RW'(rresp), RW'(e.r));
            end
         end
      end
   end

   // sel: 0 aw, 1 w, 2 aw+w, 3 ar; returns just after the handshake edge
   task automatic wait_hs(input int sel);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge aclk);
         case (sel)
            0:       ok = awready;
            1:       ok = wready;
            2:       ok = awready && wready;
            default: ok = arready;
         endcase
      end
      if (!ok) chk("handshake_timeout", RW'(sel), RW'(99));
      @(posedge aclk); #1;
   endtask

   // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W
   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] er, input int skew, input int bp);
      exp_b.push_back(er);
      bready = (bp == 0);
      awaddr = addr; wdata = data; wstrb = strb;
      if (skew == 0) begin
         awvalid = 1; wvalid = 1; wait_hs(2); awvalid = 0; wvalid = 0;
      end else if (skew > 0) begin
         wvalid = 1; wait_hs(1); wvalid = 0;
         for (int i = 1; i < skew; i++) begin
            @(negedge aclk); chk("gap_w_first", RW'({awready, wready}), RW'(2'b10));
            @(posedge aclk); #1;
         end
         awvalid = 1; wait_hs(0); awvalid = 0;
      end else begin
         awvalid = 1; wait_hs(0); awvalid = 0;
         for (int i = 1; i < -skew; i++) begin
            @(negedge aclk); chk("gap_aw_first", RW'({awready, wready}), RW'(2'b01));
            @(posedge aclk); #1;
         end
         wvalid = 1; wait_hs(1); wvalid = 0;
      end
      if (er == 2'b00)
         for (int b = 0; b < 4; b++) if (strb[b]) mdl[addr[7:2]][8*b +: 8] = data[8*b +: 8];
      @(negedge aclk);
      chk("bvalid_latency", RW'(bvalid), 1);
      if (bp > 0) begin
         for (int i = 0; i < bp; i++) begin
            if (i > 0) @(negedge aclk);
            chk("bvalid_held", RW'(bvalid), 1);
            chk("bresp_held", RW'(bresp), RW'(er));
            chk("wready_blocked", RW'({awready, wready}), 0);
         end
         @(posedge aclk); #1; bready = 1;
         @(negedge aclk);
      end
      @(posedge aclk); #1;
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [31:0] ed, input logic [1:0] er, input int bp);
      exp_r.push_back('{d: ed, r: er});
      rready = (bp == 0);
      araddr = addr; arvalid = 1; wait_hs(3); arvalid = 0;
      @(negedge aclk);
      chk("rvalid_latency", RW'(rvalid), 1);
      if (bp > 0) begin
         for (int i = 0; i < bp; i++) begin
            if (i > 0) @(negedge aclk);
            chk("rvalid_held", RW'(rvalid), 1);
            chk("rdata_held", RW'(rdata), RW'(ed));
            chk("arready_blocked", RW'(arready), 0);
         end
         @(posedge aclk); #1; rready = 1;
         @(negedge aclk);
      end
      @(posedge aclk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
      for (int i = 0; i < int'(NR); i++) mdl[i] = 32'h0;

      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("reset_outputs", RW'({awready, wready, arready, bvalid, rvalid}), 0);
      end
      @(posedge aclk); #1; areset = 0;
      @(posedge aclk); @(negedge aclk);
      chk("ready_after_reset", RW'({awready, wready, arready}), RW'(3'b111));
      chk("regs_reset", regs_o, flat());
      @(posedge aclk); #1;
      do_read(8'h00, 32'h0, 2'b00, 0);

      do_write(8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0);
      do_read(8'h04, 32'hDEADBEEF, 2'b00, 0);

      do_write(8'h08, 32'h11223344, 4'b0101, 2'b00, 3, 0);
      @(negedge aclk); chk("reg2_w_first", RW'(regs_o[2*32 +: 32]), RW'(32'h00220044));
      @(posedge aclk); #1;
      do_write(8'h10, 32'h11223344, 4'b0101, 2'b00, -2, 0);
      @(negedge aclk); chk("reg4_aw_first", RW'(regs_o[4*32 +: 32]), RW'(32'h00220044));
      chk("regs_after_skew", regs_o, flat());
      @(posedge aclk); #1;

      do_write(8'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0);
      @(negedge aclk); chk("regs_oor_unchanged", regs_o, flat());
      @(posedge aclk); #1;
      do_read(8'h7C, 32'h0, 2'b10, 0);

      do_write(8'h14, 32'h12345678, 4'hF, 2'b00, 0, 5);
      do_read(8'h14, 32'h12345678, 2'b00, 4);

      do_write(8'h0C, 32'hA5A5A5A5, 4'hF, 2'b00, 0, 0);
      exp_b.push_back(2'b00);
      exp_r.push_back('{d: 32'hA5A5A5A5, r: 2'b00});
      bready = 1; rready = 1;
      awaddr = 8'h0C; wdata = 32'h5A5A5A5A; wstrb = 4'hF; araddr = 8'h0C;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge aclk); chk("collide_ready", RW'({awready, wready, arready}), RW'(3'b111));
      @(posedge aclk); #1; awvalid = 0; wvalid = 0; arvalid = 0;
      mdl[3] = 32'h5A5A5A5A;
      @(negedge aclk); @(posedge aclk); #1;
      do_read(8'h0C, 32'h5A5A5A5A, 2'b00, 0);
      @(negedge aclk); chk("regs_before_reset", regs_o, flat());
      @(posedge aclk); #1;

      bready = 0;
      awaddr = 8'h18; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      awvalid = 1; wvalid = 1; wait_hs(2); awvalid = 0; wvalid = 0;
      @(negedge aclk); chk("bvalid_pre_reset", RW'(bvalid), 1);
      @(posedge aclk); #1; areset = 1; #1;
      for (int i = 0; i < int'(NR); i++) mdl[i] = 32'h0;
      chk("bvalid_dropped", RW'(bvalid), 0);
      chk("regs_cleared", regs_o, flat());
      chk("ready_in_reset", RW'({awready, wready, arready}), 0);
      @(posedge aclk); @(posedge aclk); #1; areset = 0; bready = 1;
      @(posedge aclk); #1;
      do_read(8'h18, 32'h0, 2'b00, 0);

      chk("queues_drained", RW'(exp_b.size() + exp_r.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
